// File: rtl/vote_pkg.sv
// Shared types for the vote button front-end.
// Holds the button count, the FSM state enum and a one-hot helper.
package vote_pkg;

  localparam int NUM_BUTTONS = 4;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    FIRE,
    REJECT,
    WAIT_RELEASE
  } state_t;

  function automatic logic is_onehot(
    input logic [NUM_BUTTONS-1:0] v
  );
    logic [NUM_BUTTONS-1:0] one;
    one = {{(NUM_BUTTONS-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parametrized two-flop synchronizer, async active-low reset to 0.
// Ports: clock, reset, d (async in), q (synchronized out).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/vote_button_conditioner.sv
// Synchronizes four candidate buttons and emits one one-hot vote pulse
// per stable single-button press; multi-button holds raise multi_press.
// Ports: clock, reset (async active-low), button1..4 (raw async),
// vote_pulse[3:0], multi_press, busy (state != IDLE).
// Optional REJECT_CNT_EN adds reject_count[7:0] (saturating).
module vote_button_conditioner
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES    = 10,
  parameter int RELEASE_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [3:0] vote_pulse,
  output logic       multi_press,
  output logic       busy
`ifdef REJECT_CNT_EN
  ,
  output logic [7:0] reject_count
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST =
    CNT_W'(RELEASE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] pat;
  logic [NUM_BUTTONS-1:0] pat_q, pat_q_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  state_t                 state, state_n;
  logic [3:0]             vote_n;
  logic                   multi_n;

  sync_2ff #(
    .WIDTH(NUM_BUTTONS)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    ({button4, button3, button2, button1}),
    .q    (pat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pat_q       <= '0;
      vote_pulse  <= '0;
      multi_press <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pat_q       <= pat_q_n;
      vote_pulse  <= vote_n;
      multi_press <= multi_n;
    end
  end

  // Outputs are registered on the edge that enters FIRE/REJECT,
  // so they are high exactly while the FSM sits in that state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_q_n = pat_q;
    vote_n  = '0;
    multi_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (pat != '0) begin
          state_n = QUALIFY;
          pat_q_n = pat;
          cnt_n   = '0;
        end
      end
      QUALIFY: begin
        if (pat == '0) begin
          state_n = IDLE;
        end else if (pat != pat_q) begin
          pat_q_n = pat;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          if (is_onehot(pat_q)) begin
            state_n = FIRE;
            vote_n  = pat_q;
          end else begin
            state_n = REJECT;
            multi_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FIRE, REJECT: begin
        state_n = WAIT_RELEASE;
        cnt_n   = '0;
      end
      WAIT_RELEASE: begin
        if (pat != '0) begin
          cnt_n = '0;
        end else if (cnt == REL_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

`ifdef REJECT_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reject_count <= '0;
    end else if (state == QUALIFY && state_n == REJECT &&
                 reject_count != 8'hFF) begin
      reject_count <= reject_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Directed, table-driven bench for vote_button_conditioner.
// Edge k=0 is the first edge sampling the new raw button pattern.
module tb_vote_button_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn   = 4'b0;
  logic [3:0] vote_pulse;
  logic       multi_press;
  logic       busy;
`ifdef REJECT_CNT_EN
  logic [7:0] reject_count;
`endif

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  vote_button_conditioner dut (
    .clock      (clock),
    .reset      (reset),
    .button1    (btn[0]),
    .button2    (btn[1]),
    .button3    (btn[2]),
    .button4    (btn[3]),
    .vote_pulse (vote_pulse),
    .multi_press(multi_press),
    .busy       (busy)
`ifdef REJECT_CNT_EN
    ,
    .reject_count(reject_count)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      if (vote_pulse != 4'b0 && multi_press) viol++;
      if (vote_pulse != 4'b0 && !$onehot(vote_pulse)) viol++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    int         ta;
    logic [3:0] b;
    int         tb;
    logic [3:0] c;
    int         tc;
    int         np;
    logic [3:0] pv;
    int         nm;
    int         ev;
    int         idle;
  } vec_t;

  // Drives a <= 3-segment pattern from edge 0 and records the
  // outputs sampled 1 time unit after each edge until busy drops.
  task automatic run(input vec_t v, output int np, output int pv,
                     output int nm, output int ev, output int idle);
    np = 0; pv = 0; nm = 0; ev = -1; idle = -1;
    for (int k = 0; k < 80; k++) begin
      btn = (k < v.ta) ? v.a :
            (k < v.tb) ? v.b :
            (k < v.tc) ? v.c : 4'b0;
      @(posedge clock); #1;
      if (vote_pulse != 4'b0) begin
        np++;
        pv = int'(vote_pulse);
        if (ev < 0) ev = k;
      end
      if (multi_press) begin
        nm++;
        if (ev < 0) ev = k;
      end
      if (k >= 2 && !busy) begin
        idle = k;
        break;
      end
    end
    btn = 4'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    int np, pv, nm, ev, idle;
    run(v, np, pv, nm, ev, idle);
    chk({tag, " pulses"}, np, v.np);
    chk({tag, " value"}, pv, int'(v.pv));
    chk({tag, " multi"}, nm, v.nm);
    chk({tag, " event_edge"}, ev, v.ev);
    chk({tag, " idle_edge"}, idle, v.idle);
    repeat (2) @(posedge clock);
    #1;
  endtask

  vec_t tbl[10];

  initial begin
    int bad;
    int np;
    tbl[0] = '{4'b0010, 20, 4'b0, 20, 4'b0, 20, 1, 4'b0010, 0, 12, 25};
    tbl[1] = '{4'b0001,  5, 4'b0,  5, 4'b0,  5, 0, 4'b0000, 0, -1,  7};
    tbl[2] = '{4'b0110, 20, 4'b0, 20, 4'b0, 20, 0, 4'b0000, 1, 12, 25};
    tbl[3] = '{4'b1000, 11, 4'b0, 11, 4'b0, 11, 1, 4'b1000, 0, 12, 17};
    tbl[4] = '{4'b0100, 10, 4'b0, 10, 4'b0, 10, 0, 4'b0000, 0, -1, 12};
    tbl[5] = '{4'b1111, 15, 4'b0, 15, 4'b0, 15, 0, 4'b0000, 1, 12, 20};
    tbl[6] = '{4'b0100, 15, 4'b1100, 40, 4'b0, 40,
               1, 4'b0100, 0, 12, 45};
    tbl[7] = '{4'b0001, 20, 4'b0000, 22, 4'b0001, 42,
               1, 4'b0001, 0, 12, 47};
    tbl[8] = '{4'b0010,  5, 4'b0011, 30, 4'b0, 30,
               0, 4'b0000, 1, 17, 35};
    tbl[9] = '{4'b0011,  3, 4'b0001, 25, 4'b0, 25,
               1, 4'b0001, 0, 15, 30};

    #2 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (vote_pulse !== 4'b0 || multi_press !== 1'b0 ||
          busy !== 1'b0) bad++;
    end
    chk("reset_hold_outputs", bad, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_vote", int'(vote_pulse), 0);
    chk("post_reset_multi", int'(multi_press), 0);
    chk("post_reset_busy", int'(busy), 0);
`ifdef REJECT_CNT_EN
    chk("post_reset_rejcnt", int'(reject_count), 0);
`endif

    for (int i = 0; i < 10; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end
`ifdef REJECT_CNT_EN
    chk("reject_count_after_table", int'(reject_count), 3);
`endif

    // Reset in the middle of a qualifying button1 hold.
    btn = 4'b0001;
    np = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      if (vote_pulse != 4'b0) np++;
    end
    chk("abort_busy_before", int'(busy), 1);
    chk("abort_no_early_pulse", np, 0);
    reset = 1'b0;
    #1;
    chk("abort_busy_async", int'(busy), 0);
    chk("abort_vote_async", int'(vote_pulse), 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    apply("after_abort",
          '{4'b0001, 20, 4'b0, 20, 4'b0, 20, 1, 4'b0001, 0, 12, 25});
`ifdef REJECT_CNT_EN
    chk("reject_count_after_reset", int'(reject_count), 0);
`endif

    chk("exclusive_onehot_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
